fcmp_pipe: RTL and testbench

//  Pipelined floating-point compare unit for FPU issue → writeback path; executes feq/flt/fle on IEEE-754 single.

---
 rtl/fcmp_if.sv | 9 +
 rtl/fcmp_pipe.sv | 55 +++++
 tb/tb_fcmp_pipe.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/fcmp_if.sv
// fcmp_if: op-issue and result channels of fcmp_pipe, each a valid/ready handshake.
interface fcmp_if #(parameter int TAG_W = 6);
  logic in_valid, in_ready, out_valid, out_ready;
  logic [1:0] op;
  logic [31:0] x1, x2, y;
  logic [TAG_W-1:0] in_tag, out_tag;
  modport master(output in_valid, op, x1, x2, in_tag, out_ready, input in_ready, out_valid, y, out_tag);
  modport slave(input in_valid, op, x1, x2, in_tag, out_ready, output in_ready, out_valid, y, out_tag);
endinterface

// File: rtl/fcmp_pipe.sv
// fcmp_pipe: two-stage feq/flt/fle on IEEE-754 single via order-preserving integer keys.
module fcmp_pipe #(
  parameter int TAG_W = 6,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  fcmp_if.slave            bus,
  output logic             busy,
  output logic [CNT_W-1:0] cmp_count
);
  logic s1_valid, s2_valid, s1_adv, s2_adv, acc, res;
  logic [1:0] s1_op;
  logic [31:0] s1_k1, s1_k2;
  logic [TAG_W-1:0] s1_tag;
  // Both zeros share one key so +0 == -0; negatives get inverted magnitude to reverse their order.
  function automatic logic [31:0] key(input logic [31:0] x);
    return x[30:0] == '0 ? 32'h8000_0000 : x[31] ? {1'b0, ~x[30:0]} : {1'b1, x[30:0]};
  endfunction
  assign s2_adv = ~s2_valid | bus.out_ready;
  assign s1_adv = s1_valid & s2_adv;
  assign bus.in_ready = ~s1_valid | s2_adv;
  assign acc = bus.in_valid & bus.in_ready;
  assign bus.out_valid = s2_valid;
  assign busy = s1_valid | s2_valid;
  always_comb res = s1_op == 2'b00 ? s1_k1 == s1_k2 : s1_op == 2'b01 ? s1_k1 < s1_k2 : s1_op == 2'b10 ? s1_k1 <= s1_k2 : 1'b0;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      s1_valid    <= 1'b0;
      s2_valid    <= 1'b0;
      s1_op       <= '0;
      s1_k1       <= '0;
      s1_k2       <= '0;
      s1_tag      <= '0;
      bus.y       <= '0;
      bus.out_tag <= '0;
      cmp_count   <= '0;
    end else begin
      s1_valid <= ~flush & (acc | (s1_valid & ~s2_adv));
      if (acc) begin
        s1_op  <= bus.op;
        s1_k1  <= key(bus.x1);
        s1_k2  <= key(bus.x2);
        s1_tag <= bus.in_tag;
      end
      if (flush) s2_valid <= 1'b0;
      else if (s2_adv) s2_valid <= s1_valid;
      if (s1_adv & ~flush) begin
        bus.y       <= {31'd0, res};
        bus.out_tag <= s1_tag;
      end
      if (~flush & s2_valid & bus.out_ready & ~&cmp_count) cmp_count <= cmp_count + 1'b1;
    end
endmodule

// File: tb/tb_fcmp_pipe.sv
// tb_fcmp_pipe: random and directed stimulus checked against an in-order queue model of fcmp_pipe.
module tb_fcmp_pipe;
  localparam int TAG_W = 6;
  localparam int CNT_W = 4;
  logic clk = 1'b0, rst = 1'b1, flush = 1'b0, busy;
  logic [CNT_W-1:0] cmp_count;
  fcmp_if #(.TAG_W(TAG_W)) bus();
  fcmp_pipe #(.TAG_W(TAG_W), .CNT_W(CNT_W)) dut(.clk(clk), .rst(rst), .flush(flush), .bus(bus), .busy(busy), .cmp_count(cmp_count));
  always #5 clk = ~clk;
  typedef struct {logic [31:0] y; logic [TAG_W-1:0] tag; int age;} ent_t;
  ent_t q[$];
  int cnt_m = 0, tests = 0, fails = 0;
  logic [31:0] y_hold;
  // Sign-magnitude ordering with both zeros treated as one value; -1 less, 0 equal, 1 greater.
  function automatic int ord(input logic [31:0] a, input logic [31:0] b);
    bit sa, sb, lt;
    sa = (a[30:0] == 0) ? 1'b0 : a[31];
    sb = (b[30:0] == 0) ? 1'b0 : b[31];
    if (sa != sb) return sa ? -1 : 1;
    if (a[30:0] == b[30:0] || (a[30:0] == 0 && b[30:0] == 0)) return 0;
    lt = a[30:0] < b[30:0];
    return (sa ? !lt : lt) ? -1 : 1;
  endfunction
  function automatic logic [31:0] exp_y(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    int r;
    r = ord(a, b);
    return op == 2'd0 ? 32'(r == 0) : op == 2'd1 ? 32'(r < 0) : op == 2'd2 ? 32'(r <= 0) : 32'd0;
  endfunction
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask
  function automatic bit m_vis();
    return q.size() > 0 && q[0].age >= 1;
  endfunction
  function automatic bit m_ir();
    return q.size() < 2 || (m_vis() && bus.out_ready);
  endfunction
  task automatic check_all();
    chk("out_valid", 32'(bus.out_valid), 32'(m_vis()));
    if (m_vis()) begin
      chk("y", bus.y, q[0].y);
      chk("out_tag", 32'(bus.out_tag), 32'(q[0].tag));
    end
    chk("busy", 32'(busy), 32'(q.size() > 0));
    chk("in_ready", 32'(bus.in_ready), 32'(m_ir()));
    chk("cmp_count", 32'(cmp_count), 32'(cnt_m));
  endtask
  // Called at negedge+1; drives one cycle, checks, advances the model, returns at the next negedge+1.
  task automatic step(input bit iv, input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                      input logic [TAG_W-1:0] tag, input bit ordy, input bit fl);
    bit vis, acc;
    bus.in_valid = iv; bus.op = op; bus.x1 = a; bus.x2 = b; bus.in_tag = tag; bus.out_ready = ordy; flush = fl;
    #1;
    check_all();
    vis = m_vis();
    acc = iv && m_ir();
    @(posedge clk);
    if (fl) q.delete();
    else begin
      if (vis && ordy) begin
        void'(q.pop_front());
        if (cnt_m < (1 << CNT_W) - 1) cnt_m++;
      end
      foreach (q[i]) q[i].age++;
      if (acc) q.push_back('{exp_y(op, a, b), tag, 0});
    end
    @(negedge clk);
    #1;
  endtask
  task automatic idle(input bit ordy);
    step(1'b0, 2'd0, 32'd0, 32'd0, '0, ordy, 1'b0);
  endtask
  task automatic lit(input string name, input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                     input logic [TAG_W-1:0] tag, input logic [31:0] ey);
    step(1'b1, op, a, b, tag, 1'b1, 1'b0);
    idle(1'b0);
    chk({name, "_valid"}, 32'(bus.out_valid), 32'd1);
    chk(name, bus.y, ey);
    chk({name, "_tag"}, 32'(bus.out_tag), 32'(tag));
    idle(1'b1);
  endtask
  function automatic logic [31:0] rnd_fp();
    case ($urandom_range(0, 5))
      0: return 32'h0000_0000;
      1: return 32'h8000_0000;
      2: return 32'h3F80_0000 ^ {$urandom_range(0, 1) == 1, 31'd0};
      3: return {1'b0, 31'($urandom_range(0, 7))};
      default: return $urandom;
    endcase
  endfunction
  initial begin
    logic [31:0] a, b;
    bus.in_valid = 0; bus.op = 0; bus.x1 = 0; bus.x2 = 0; bus.in_tag = 0; bus.out_ready = 0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_y", bus.y, 32'd0);
    chk("rst_out_tag", 32'(bus.out_tag), 32'd0);
    chk("rst_cnt", 32'(cmp_count), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    lit("fle_1_2", 2'd2, 32'h3F80_0000, 32'h4000_0000, 6'd5, 32'd1);
    lit("flt_1_2", 2'd1, 32'h3F80_0000, 32'h4000_0000, 6'd5, 32'd1);
    lit("feq_1_2", 2'd0, 32'h3F80_0000, 32'h4000_0000, 6'd5, 32'd0);
    lit("feq_nz_pz", 2'd0, 32'h8000_0000, 32'h0000_0000, 6'd9, 32'd1);
    lit("flt_nz_pz", 2'd1, 32'h8000_0000, 32'h0000_0000, 6'd10, 32'd0);
    lit("fle_pz_nz", 2'd2, 32'h0000_0000, 32'h8000_0000, 6'd11, 32'd1);
    lit("flt_m2_m1", 2'd1, 32'hC000_0000, 32'hBF80_0000, 6'd12, 32'd1);
    lit("fle_m1_m2", 2'd2, 32'hBF80_0000, 32'hC000_0000, 6'd13, 32'd0);
    lit("op3", 2'd3, 32'h0000_0000, 32'h0000_0000, 6'd14, 32'd0);
    rst = 1'b1; #1; q.delete(); cnt_m = 0;
    @(negedge clk); rst = 1'b0; #1;
    for (int i = 0; i < 8; i++) step(1'b1, 2'($urandom_range(0, 2)), rnd_fp(), rnd_fp(), 6'(i), 1'b1, 1'b0);
    idle(1'b1); idle(1'b1);
    chk("b2b_count8", 32'(cmp_count), 32'd8);
    for (int i = 0; i < 8; i++) step(1'b1, 2'd0, 32'd0, 32'd0, 6'(i), 1'b1, 1'b0);
    idle(1'b1); idle(1'b1);
    chk("cnt_saturate", 32'(cmp_count), 32'd15);
    step(1'b1, 2'd1, 32'h3F80_0000, 32'h4000_0000, 6'd1, 1'b0, 1'b0);
    step(1'b1, 2'd1, 32'h4000_0000, 32'h3F80_0000, 6'd2, 1'b0, 1'b0);
    y_hold = bus.y;
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 2'd2, 32'h4000_0000, 32'h4000_0000, 6'd3, 1'b0, 1'b0);
      chk("stall_in_ready", 32'(bus.in_ready), 32'd0);
      chk("stall_y", bus.y, y_hold);
    end
    step(1'b1, 2'd2, 32'h4000_0000, 32'h4000_0000, 6'd3, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) idle(1'b1);
    chk("stall_all_gone", 32'(busy), 32'd0);
    step(1'b1, 2'd0, 32'h1, 32'h1, 6'd20, 1'b0, 1'b0);
    step(1'b1, 2'd0, 32'h2, 32'h1, 6'd21, 1'b0, 1'b0);
    step(1'b1, 2'd0, 32'h3, 32'h1, 6'd22, 1'b1, 1'b1);
    chk("flush_busy", 32'(busy), 32'd0);
    chk("flush_out_valid", 32'(bus.out_valid), 32'd0);
    chk("flush_cnt", 32'(cmp_count), 32'd15);
    step(1'b1, 2'd1, 32'h1, 32'h2, 6'd30, 1'b0, 1'b0);
    step(1'b1, 2'd1, 32'h2, 32'h1, 6'd31, 1'b0, 1'b0);
    rst = 1'b1; #1;
    chk("rst_mid_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_mid_cnt", 32'(cmp_count), 32'd0);
    chk("rst_mid_busy", 32'(busy), 32'd0);
    q.delete(); cnt_m = 0;
    @(negedge clk); rst = 1'b0; #1;
    for (int i = 0; i < 3000; i++) begin
      a = rnd_fp();
      b = ($urandom_range(0, 4) == 0) ? a : rnd_fp();
      step($urandom_range(0, 3) != 0, 2'($urandom), a, b, 6'($urandom), $urandom_range(0, 3) != 0, $urandom_range(0, 40) == 0);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
